// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared states and AHB-Lite encodings for the UART image loader
package loader_pkg;

  typedef enum logic [2:0] {
    ST_HDR,
    ST_DATA,
    ST_ADDR,
    ST_WDATA,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [1:0] HTRANS_IDLE     = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ   = 2'b10;
  localparam logic [2:0] HSIZE_WORD      = 3'b010;
  localparam logic [2:0] HBURST_SINGLE   = 3'b000;
  localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

endpackage

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - packs four accepted bytes into a little-endian 32-bit word
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  cnt_q;
  logic [23:0] shift_q;

  // The fourth byte completes the word combinationally so the caller can
  // capture it on the same edge the byte is accepted.
  assign word       = {data, shift_q};
  assign word_valid = accept && (cnt_q == 2'd3);

  // Byte counter wraps naturally on the fourth byte; older bytes shift down.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= 2'd0;
      shift_q <= 24'd0;
    end else if (clear) begin
      cnt_q   <= 2'd0;
      shift_q <= 24'd0;
    end else if (accept) begin
      cnt_q   <= cnt_q + 2'd1;
      shift_q <= {data, shift_q[23:8]};
    end
  end

endmodule

// File: rtl/ahb_uart_loader.sv
// rtl/ahb_uart_loader.sv - boot loader writing a UART byte image to memory over AHB-Lite
module ahb_uart_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          AWIDTH    = 15
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic [31:0] haddr,
  output logic [1:0]  htrans,
  output logic        hwrite,
  output logic [2:0]  hsize,
  output logic [2:0]  hburst,
  output logic [3:0]  hprot,
  output logic [31:0] hwdata,
  input  logic        hready,
  input  logic        hresp,
  output logic        cpu_rst_hold,
  output logic        load_done,
  output logic        load_err
);
  import loader_pkg::*;

  localparam logic [31:0] MAX_WORDS = 32'(2 ** (AWIDTH - 2));

  state_t      state_q, state_d;
  logic [31:0] count_q;
  logic [31:0] index_q;
  logic [31:0] wdata_q;
  logic [31:0] pk_word;
  logic        pk_valid;
  logic        pk_clear;
  logic        accept;

  assign accept   = rx_valid && rx_ready;
  assign pk_clear = (state_d != state_q) && ((state_d == ST_HDR) || (state_d == ST_DATA));

  byte_packer u_packer (
    .clk        (sys_clk),
    .rst        (sys_rst),
    .clear      (pk_clear),
    .accept     (accept),
    .data       (rx_data),
    .word       (pk_word),
    .word_valid (pk_valid)
  );

  // Outputs are decoded from state and registers only, never from inputs.
  assign rx_ready     = (state_q == ST_HDR) || (state_q == ST_DATA);
  assign htrans       = (state_q == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign hwrite       = (state_q == ST_ADDR);
  assign haddr        = BASE_ADDR + {index_q[29:0], 2'b00};
  assign hwdata       = wdata_q;
  assign hsize        = HSIZE_WORD;
  assign hburst       = HBURST_SINGLE;
  assign hprot        = HPROT_DATA_PRIV;
  assign cpu_rst_hold = (state_q != ST_DONE);
  assign load_done    = (state_q == ST_DONE);
  assign load_err     = (state_q == ST_ERR);

  // State register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state_q <= ST_HDR;
    else         state_q <= state_d;
  end

  // Next-state decode: header, byte collection, one bus transfer per word.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HDR: begin
        if (pk_valid) begin
          if (pk_word == 32'd0)           state_d = ST_DONE;
          else if (pk_word > MAX_WORDS)   state_d = ST_ERR;
          else                            state_d = ST_DATA;
        end
      end
      ST_DATA:  if (pk_valid) state_d = ST_ADDR;
      ST_ADDR:  if (hready)   state_d = ST_WDATA;
      ST_WDATA: begin
        if (hready) begin
          if (hresp)                           state_d = ST_ERR;
          else if (index_q + 32'd1 == count_q) state_d = ST_DONE;
          else                                 state_d = ST_DATA;
        end
      end
      default: state_d = state_q;
    endcase
  end

  // Word count, word index and write-data holding registers.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      count_q <= 32'd0;
      index_q <= 32'd0;
      wdata_q <= 32'd0;
    end else begin
      if (state_q == ST_HDR && pk_valid) begin
        count_q <= pk_word;
        index_q <= 32'd0;
      end
      if (state_q == ST_DATA && pk_valid) wdata_q <= pk_word;
      if (state_q == ST_WDATA && hready && !hresp) index_q <= index_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_ahb_uart_loader.sv
// tb/tb_ahb_uart_loader.sv - scoreboard bench for the AHB UART loader
module tb_ahb_uart_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic        hready = 1'b1;
  logic        hresp = 1'b0;
  logic        cpu_rst_hold;
  logic        load_done;
  logic        load_err;

  ahb_uart_loader #(.BASE_ADDR(BASE), .AWIDTH(15)) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .haddr        (haddr),
    .htrans       (htrans),
    .hwrite       (hwrite),
    .hsize        (hsize),
    .hburst       (hburst),
    .hprot        (hprot),
    .hwdata       (hwdata),
    .hready       (hready),
    .hresp        (hresp),
    .cpu_rst_hold (cpu_rst_hold),
    .load_done    (load_done),
    .load_err     (load_err)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;
  xfer_t sb[$];

  int aw_waits = 0;
  int dw_waits = 0;
  int err_word = -1;
  int xfer_cnt = 0;
  bit dphase   = 0;
  int awc      = 0;
  int dcnt     = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Slave model: wait states, error injection, scoreboard compare.
  initial begin
    forever begin
      @(negedge sys_clk);
      if (sys_rst) begin
        hready = 1'b1; hresp = 1'b0; dphase = 0; awc = 0; dcnt = 0;
      end else if (dphase) begin
        if (sb.size() != 0) check_eq("hwdata", hwdata, sb[0].data);
        check_eq("data_htrans_idle", 32'(htrans), 32'd0);
        if (xfer_cnt - 1 == err_word) begin
          if (dcnt == 0) begin
            hready = 1'b0; hresp = 1'b1; dcnt++;
          end else begin
            hready = 1'b1; hresp = 1'b1; dphase = 0; dcnt = 0;
            if (sb.size() != 0) void'(sb.pop_front());
          end
        end else if (dcnt < dw_waits) begin
          hready = 1'b0; hresp = 1'b0; dcnt++;
        end else begin
          hready = 1'b1; hresp = 1'b0; dphase = 0; dcnt = 0;
          if (sb.size() != 0) void'(sb.pop_front());
        end
      end else if (htrans == 2'b10) begin
        check_eq("xfer_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) check_eq("haddr", haddr, sb[0].addr);
        check_eq("hwrite", 32'(hwrite), 32'd1);
        if (awc < aw_waits) begin
          hready = 1'b0; hresp = 1'b0; awc++;
        end else begin
          hready = 1'b1; hresp = 1'b0; awc = 0; dphase = 1; xfer_cnt++;
        end
      end else begin
        hready = 1'b1; hresp = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, output bit ok);
    int n = 0;
    @(negedge sys_clk);
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 50) begin
      @(negedge sys_clk);
      n++;
    end
    ok = rx_ready;
    if (ok) @(posedge sys_clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, output bit ok);
    bit b_ok;
    ok = 1;
    for (int i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8], b_ok);
      ok = ok && b_ok;
    end
  endtask

  task automatic send_data(input int idx, input logic [31:0] w);
    bit ok;
    xfer_t x;
    x.addr = BASE + 32'(4 * idx);
    x.data = w;
    sb.push_back(x);
    send_word(w, ok);
    check_eq("data_accepted", 32'(ok), 32'd1);
  endtask

  task automatic send_hdr(input logic [31:0] n);
    bit ok;
    send_word(n, ok);
    check_eq("hdr_accepted", 32'(ok), 32'd1);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!load_done && n < 100) begin
      @(posedge sys_clk);
      #1 n++;
    end
  endtask

  task automatic do_reset();
    sys_rst  = 1'b1;
    rx_valid = 1'b0;
    repeat (2) @(posedge sys_clk);
    #2;
    sb.delete();
    xfer_cnt = 0; aw_waits = 0; dw_waits = 0; err_word = -1;
    sys_rst = 1'b0;
  endtask

  task automatic check_reset_values(input string pfx);
    check_eq({pfx, "_htrans"}, 32'(htrans), 32'd0);
    check_eq({pfx, "_hwrite"}, 32'(hwrite), 32'd0);
    check_eq({pfx, "_haddr"}, haddr, BASE);
    check_eq({pfx, "_hwdata"}, hwdata, 32'd0);
    check_eq({pfx, "_cpu_rst_hold"}, 32'(cpu_rst_hold), 32'd1);
    check_eq({pfx, "_load_done"}, 32'(load_done), 32'd0);
    check_eq({pfx, "_load_err"}, 32'(load_err), 32'd0);
    check_eq({pfx, "_rx_ready"}, 32'(rx_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat;
    bit  ok;

    #1;
    check_reset_values("rst");
    check_eq("rst_hsize", 32'(hsize), 32'd2);
    check_eq("rst_hburst", 32'(hburst), 32'd0);
    check_eq("rst_hprot", 32'(hprot), 32'd3);

    // Two-word image, zero-wait slave.
    do_reset();
    send_hdr(32'd2);
    send_data(0, 32'h1234_5678);
    send_data(1, 32'hDEAD_BEEF);
    wait_done(lat);
    check_eq("t1_latency", 32'(lat), 32'd2);
    check_eq("t1_load_done", 32'(load_done), 32'd1);
    check_eq("t1_cpu_rst_hold", 32'(cpu_rst_hold), 32'd0);
    check_eq("t1_load_err", 32'(load_err), 32'd0);
    check_eq("t1_sb_empty", 32'(sb.size()), 32'd0);
    check_eq("t1_xfers", 32'(xfer_cnt), 32'd2);
    check_eq("t1_rx_ready", 32'(rx_ready), 32'd0);
    rx_valid = 1'b1;
    repeat (5) @(posedge sys_clk);
    #1 rx_valid = 1'b0;
    check_eq("t1_post_xfers", 32'(xfer_cnt), 32'd2);
    check_eq("t1_post_done", 32'(load_done), 32'd1);

    // Empty image.
    do_reset();
    send_hdr(32'd0);
    check_eq("t2_load_done", 32'(load_done), 32'd1);
    check_eq("t2_cpu_rst_hold", 32'(cpu_rst_hold), 32'd0);
    repeat (3) @(posedge sys_clk);
    #1 check_eq("t2_xfers", 32'(xfer_cnt), 32'd0);

    // Wait states: 3 in address phase, 2 in data phase.
    do_reset();
    aw_waits = 3;
    dw_waits = 2;
    send_hdr(32'd1);
    send_data(0, 32'hCAFE_F00D);
    wait_done(lat);
    check_eq("t3_latency", 32'(lat), 32'd7);
    check_eq("t3_load_done", 32'(load_done), 32'd1);
    check_eq("t3_sb_empty", 32'(sb.size()), 32'd0);

    // Two-cycle ERROR on word 1 of 3.
    do_reset();
    err_word = 1;
    send_hdr(32'd3);
    send_data(0, 32'h0101_0202);
    send_data(1, 32'h0303_0404);
    repeat (20) @(posedge sys_clk);
    #1;
    check_eq("t4_load_err", 32'(load_err), 32'd1);
    check_eq("t4_cpu_rst_hold", 32'(cpu_rst_hold), 32'd1);
    check_eq("t4_load_done", 32'(load_done), 32'd0);
    check_eq("t4_rx_ready", 32'(rx_ready), 32'd0);
    check_eq("t4_xfers", 32'(xfer_cnt), 32'd2);
    check_eq("t4_sb_empty", 32'(sb.size()), 32'd0);
    send_byte(8'h55, ok);
    check_eq("t4_rx_blocked", 32'(ok), 32'd0);
    check_eq("t4_post_xfers", 32'(xfer_cnt), 32'd2);

    // Oversize header.
    do_reset();
    send_hdr(32'h0000_2001);
    check_eq("t5_load_err", 32'(load_err), 32'd1);
    check_eq("t5_rx_ready", 32'(rx_ready), 32'd0);
    check_eq("t5_htrans", 32'(htrans), 32'd0);
    repeat (5) @(posedge sys_clk);
    #1 check_eq("t5_xfers", 32'(xfer_cnt), 32'd0);

    // Reset during WDATA of word 0, then reload.
    do_reset();
    dw_waits = 3;
    send_hdr(32'd1);
    send_data(0, 32'h1111_2222);
    lat = 0;
    while (!dphase && lat < 50) begin
      @(posedge sys_clk);
      #2 lat++;
    end
    check_eq("t6_reached_wdata", 32'(dphase), 32'd1);
    sys_rst = 1'b1;
    #1 check_reset_values("t6_midrst");
    sb.delete();
    dphase = 0; xfer_cnt = 0; dw_waits = 0;
    repeat (2) @(posedge sys_clk);
    #2 sys_rst = 1'b0;
    send_hdr(32'd1);
    send_data(0, 32'hA5A5_5A5A);
    wait_done(lat);
    check_eq("t6_latency", 32'(lat), 32'd2);
    check_eq("t6_load_done", 32'(load_done), 32'd1);
    check_eq("t6_xfers", 32'(xfer_cnt), 32'd1);
    check_eq("t6_sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_uart_loader.md
# ahb_uart_loader

Boot-time AHB-Lite write master that sits directly upstream of the CPU instruction/data memory on the same AHB-Lite bus segment. It receives a program image as a byte stream from the UART receiver. It packs the bytes into 32-bit little-endian words and writes them as single NONSEQ word transfers starting at `BASE_ADDR`. It holds the CPU in reset until the image is fully written, then releases it. Any bus error latches a sticky fault.

## Interface
- `BASE_ADDR`, 32'h0000_0000: byte address of the first written word; word aligned.
- `AWIDTH`, 15: memory byte-address width. `MAX_WORDS` = 2**(`AWIDTH`-2).
- `sys_clk` in 1: single clock. All logic is rising-edge.
- `sys_rst` in 1: reset, asynchronous and active-high.
- `rx_valid` in 1: byte available from the UART receiver.
- `rx_data` in 8: received byte.
- `rx_ready` out 1: loader accepts a byte. A transfer occurs on `rx_valid & rx_ready`.
- `haddr` out 32: AHB address.
- `htrans` out 2: only 2'b00 (IDLE) or 2'b10 (NONSEQ).
- `hwrite` out 1: 1 during the NONSEQ address phase, else 0.
- `hsize` out 3: constant 3'b010.
- `hburst` out 3: constant 3'b000.
- `hprot` out 4: constant 4'b0011.
- `hwdata` out 32: write data for the data phase.
- `hready` in 1: transfer-complete or wait signal from the slave.
- `hresp` in 1: 1 means ERROR.
- `cpu_rst_hold` out 1: 1 holds the CPU in reset.
- `load_done` out 1: image written successfully.
- `load_err` out 1: sticky fault (bus error or oversize image).

## Operation
- Image format:
  - 4-byte header: word count N, little-endian (first byte is bits 7:0).
  - Then N words, each 4 bytes, little-endian.
- Word i is written to `BASE_ADDR` + 4*i.
- FSM states: HDR, DATA, ADDR, WDATA, DONE, ERR. Reset state is HDR.
- HDR:
  - `rx_ready`=1; collect 4 bytes into the count register.
  - On the 4th byte: N==0 goes to DONE; N>`MAX_WORDS` goes to ERR; otherwise go to DATA with word index = 0.
- DATA:
  - `rx_ready`=1; collect 4 bytes into the word register.
  - On the 4th byte, go to ADDR.
- ADDR:
  - Drive `htrans`=NONSEQ, `hwrite`=1, `haddr`=`BASE_ADDR`+{index,2'b00}; `rx_ready`=0.
  - If `hready`=1 at the edge, go to WDATA; otherwise hold all address-phase signals.
- WDATA:
  - Drive `htrans`=IDLE and `hwdata`=word; `hwdata` is held until the phase completes.
  - Wait while `hready`=0.
  - `hready`=1 with `hresp`=1 goes to ERR.
  - `hready`=1 with `hresp`=0: increment index; if index+1==N go to DONE, else go to DATA.
  - `hresp`=1 with `hready`=0 (first error cycle) is ignored. Only the final cycle decides.
- DONE: terminal. `load_done`=1, `cpu_rst_hold`=0, `rx_ready`=0. Further bytes are ignored.
- ERR: terminal. `load_err`=1, `cpu_rst_hold`=1, `rx_ready`=0, `htrans`=IDLE.
- Byte counter is 2 bits and wraps 3→0 on each 4th accepted byte. It is cleared on entry to HDR and DATA.
- Index and count are 32-bit registers; the comparison is against the full 32-bit N.

## Timing
- Reset values:
  - Bus outputs: `htrans`=00, `hwrite`=0, `haddr`=`BASE_ADDR`, `hwdata`=0.
  - Status: `cpu_rst_hold`=1, `load_done`=0, `load_err`=0, `rx_ready`=1 (state HDR).
- Constant outputs (`hsize`, `hburst`, `hprot`) hold their values during reset.
- All bus and status outputs are registered or decoded directly from the state register. There is no combinational path from `rx_*` or `h*` inputs to any output.
- Per-word latency with zero-wait-state memory:
  - 4 byte cycles, then 1 ADDR cycle, then 1 WDATA cycle: 6 cycles minimum per word.
  - Each slave wait state adds 1 cycle.
- Transfers never overlap: the next NONSEQ is issued only after the previous data phase completes.
- `load_done` rises in the cycle after the last data phase completes with `hready`=1. `cpu_rst_hold` falls in the same cycle.
- `sys_rst` asserted mid-transfer: immediate return to reset values. The image is restarted from the header. A partial memory image is acceptable.

## Structure
- Package `loader_pkg` contains:
  - State enum.
  - `HTRANS_IDLE`/`HTRANS_NONSEQ` codes.
  - `HSIZE_WORD`, `HBURST_SINGLE`, `HPROT_DATA_PRIV` constants.
- Sub-module `byte_packer`: 2-bit byte counter plus 32-bit little-endian shift register.
  - Inputs: clear and accept.
  - Outputs: word and `word_valid` pulse.
  - It is reused for both the header and data words.

## Test plan
- Bytes 02 00 00 00, 78 56 34 12, EF BE AD DE, zero-wait slave: writes 0x12345678 at `BASE_ADDR` and 0xDEADBEEF at `BASE_ADDR`+4, in that order. Then `load_done`=1 and `cpu_rst_hold`=0.
- Header 00 00 00 00: `load_done`=1 in the next cycle with no AHB transfer issued.
- Single word, slave inserts 3 wait states in the address phase and 2 in the data phase: `haddr` and `hwdata` stay stable throughout. Completion follows 5 extra cycles.
- Two-cycle ERROR response on word 1 of 3: `load_err`=1 and `cpu_rst_hold` stays 1. No third transfer is issued and `rx_ready`=0.
- Header N=`MAX_WORDS`+1 (0x2001 with defaults): enters ERR with no bus transfer.
- `sys_rst` pulsed during WDATA of word 0, then a full 1-word image is sent: outputs show reset values in the cycle of assertion, and the second image loads correctly.
